// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master user port among N_REQ
// requesters. Exactly one master transaction is in flight at any time.
module axil_req_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      m_start,
    output logic                      m_write_en,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_next_ptr;
    logic              w_accept;

    // Winner search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            v_idx = (32'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && req_valid[ID_W'(v_idx)]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(v_idx);
            end
        end
        if (w_winner == ID_W'(N_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_winner + ID_W'(1);
        end
    end

    assign w_accept = (r_state == StIdle) && w_found;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_found) w_state_d = StIssue;
            StIssue: w_state_d = StWait;
            StWait:  if (m_done) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Command capture on accept, pointer advance, and response data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_write <= req_write[w_winner];
                r_cmd_addr  <= req_addr[32'(w_winner)*ADDR_W +: ADDR_W];
                r_cmd_wdata <= req_wdata[32'(w_winner)*DATA_W +: DATA_W];
                r_grant_id  <= w_winner;
                r_rr_ptr    <= w_next_ptr;
            end
            if ((r_state == StWait) && m_done) begin
                r_rsp_rdata <= r_cmd_write ? '0 : m_rdata;
            end
        end
    end

    // Outputs; req_ready is gated by rst so every output reads 0 during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (w_accept && !rst) req_ready[w_winner] = 1'b1;
        if (r_state == StResp) rsp_valid[r_grant_id] = 1'b1;
        m_start = (r_state == StIssue);
        busy    = (r_state != StIdle);
    end

    assign m_write_en = r_cmd_write;
    assign m_addr     = r_cmd_addr;
    assign m_wdata    = r_cmd_wdata;
    assign rsp_rdata  = r_rsp_rdata;
    assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Self-checking bench for axil_req_arbiter: directed table, randomized
// transactions against a round-robin reference model, contention and reset.
module tb_axil_req_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          m_start;
    logic          m_write_en;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = '0;
    logic          m_done = 1'b0;
    logic          busy;
    logic [1:0]    grant_id;

    logic          a_wr[N];
    logic [31:0]   a_addr[N];
    logic [31:0]   a_wdata[N];

    int n_checks = 0;
    int n_err    = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_write[i]         = a_wr[i];
            req_addr[i*32 +: 32]  = a_addr[i];
            req_wdata[i*32 +: 32] = a_wdata[i];
        end
    end

    axil_req_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .m_start    (m_start),
        .m_write_en (m_write_en),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_done     (m_done),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    typedef struct {
        logic [3:0]  mask;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          expw;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    // Reference: first set bit at or after ptr, modulo N.
    function automatic int model_winner(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            a_wr[i]    = 1'($urandom);
            a_addr[i]  = $urandom;
            a_wdata[i] = $urandom;
        end
    endtask

    // One full transaction starting in IDLE; busy-time req_valid noise must not be accepted.
    task automatic run_txn(input logic [3:0] mask, input int expw, input logic [31:0] rdata,
                           input int lat);
        logic [31:0] exp_rd;
        exp_rd = a_wr[expw] ? 32'h0 : rdata;
        @(negedge clk);
        req_valid = mask;
        m_done    = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("req_ready", req_ready, oh(expw));
        @(negedge clk);
        req_valid = 4'($urandom);
        #1;
        check("m_start", m_start, 1);
        check("grant_id", grant_id, expw);
        check("m_write_en", m_write_en, a_wr[expw]);
        check("m_addr", m_addr, a_addr[expw]);
        check("m_wdata", m_wdata, a_wdata[expw]);
        check("ready_busy", req_ready, 0);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            #1;
            check("wait_start", m_start, 0);
            check("wait_busy", busy, 1);
            check("wait_rsp", rsp_valid, 0);
            check("wait_ready", req_ready, 0);
        end
        @(negedge clk);
        m_done  = 1'b1;
        m_rdata = rdata;
        #1;
        check("done_start", m_start, 0);
        check("done_ready", req_ready, 0);
        @(negedge clk);
        m_done    = 1'b0;
        m_rdata   = $urandom;
        req_valid = '0;
        #1;
        check("rsp_valid", rsp_valid, oh(expw));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("addr_stable", m_addr, a_addr[expw]);
        check("resp_ready", req_ready, 0);
        @(negedge clk);
        #1;
        check("back_idle", busy, 0);
        check("rsp_cleared", rsp_valid, 0);
        check("rdata_hold", rsp_rdata, exp_rd);
        m_ptr = (expw + 1) % N;
    endtask

    initial begin
        int grants;
        int outstanding;
        int done_at;
        int w;
        logic [3:0] mask;

        tbl[0] = '{4'b0010, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1, 1};
        tbl[1] = '{4'b0100, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 2, 2};
        tbl[2] = '{4'b1001, 1'b0, 32'h0000_0100, 32'h0,         32'hCAFE_0001, 0, 3};
        tbl[3] = '{4'b1001, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 32'h1111_1111, 3, 0};
        tbl[4] = '{4'b1001, 1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_0002, 1, 3};
        tbl[5] = '{4'b1111, 1'b0, 32'h0000_0400, 32'h0,         32'h0BAD_F00D, 0, 0};
        tbl[6] = '{4'b0101, 1'b1, 32'h0000_0500, 32'h7777_0000, 32'h2222_2222, 2, 2};
        tbl[7] = '{4'b0011, 1'b0, 32'h0000_0600, 32'h0,         32'h8765_4321, 1, 0};

        randomize_fields();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_start", m_start, 0);
        check("rst_addr", m_addr, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_ready", req_ready, 0);

        // Directed table: single read, single write, wrap fairness, ties.
        for (int r = 0; r < 8; r++) begin
            randomize_fields();
            a_wr[tbl[r].expw]    = tbl[r].wr;
            a_addr[tbl[r].expw]  = tbl[r].addr;
            a_wdata[tbl[r].expw] = tbl[r].wdata;
            run_txn(tbl[r].mask, tbl[r].expw, tbl[r].rdata, tbl[r].lat);
        end

        // Random transactions against the round-robin model; empty masks pulse a stray m_done.
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(0, 15));
            if (mask == 4'b0000) begin
                @(negedge clk);
                req_valid = '0;
                m_done    = 1'b1;
                #1;
                check("stray_ready", req_ready, 0);
                @(negedge clk);
                m_done = 1'b0;
                #1;
                check("stray_busy", busy, 0);
                check("stray_rsp", rsp_valid, 0);
            end else begin
                randomize_fields();
                w = model_winner(mask, m_ptr);
                run_txn(mask, w, $urandom, $urandom_range(0, 3));
            end
        end

        // Contention: all requesters held from reset, master answers 3 cycles after m_start.
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("rst_ready_gated", req_ready, 0);
        @(negedge clk);
        rst         = 1'b0;
        grants      = 0;
        outstanding = 0;
        done_at     = -1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (cyc != 0) @(negedge clk);
            m_done  = (cyc == done_at);
            m_rdata = $urandom;
            if (cyc == done_at) outstanding = 0;
            #1;
            if (req_ready != 4'b0000) begin
                check("cont_order", req_ready, oh(grants % N));
                grants++;
            end
            if (m_start) begin
                check("cont_single_start", outstanding, 0);
                outstanding = 1;
                done_at     = cyc + 3;
            end
        end
        check("cont_grants", (grants >= 8) ? 1 : 0, 1);
        m_done    = 1'b0;
        req_valid = '0;

        // Reset while waiting on m_done.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        randomize_fields();
        a_addr[2]  = 32'hA5A5_0F00;
        a_wdata[2] = 32'h5A5A_00F0;
        a_wr[2]    = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        check("rw_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("rw_in_wait", busy, 1);
        check("rw_addr", m_addr, 32'hA5A5_0F00);
        #2;
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("rw_busy", busy, 0);
        check("rw_start", m_start, 0);
        check("rw_wen", m_write_en, 0);
        check("rw_addr0", m_addr, 0);
        check("rw_wdata0", m_wdata, 0);
        check("rw_grant0", grant_id, 0);
        check("rw_rsp0", rsp_valid, 0);
        check("rw_rd0", rsp_rdata, 0);
        check("rw_ready0", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_after_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rw_after_grant", grant_id, 0);
        check("rw_after_start", m_start, 1);
        check("rw_no_rsp", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
